// File: rtl/spike_encoder.sv
// Race-logic spike encoder: a value V loaded on a grst edge fires q V+1 edges later; all-ones never fires.
// One-entry pending buffer; in_ready = ~pend_v | grst, so a grst edge can bypass a new value straight into the count.
module spike_encoder #(
  parameter int WIDTH      = 4,
  parameter bit PULSE_MODE = 1'b0
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             grst,
  input  logic [WIDTH-1:0] in_val,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             q,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, COUNT, FIRED} state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] pend, pend_nxt;
  logic             pend_v, pend_v_nxt;
  logic             q_nxt;
  logic             transfer;
  logic [WIDTH-1:0] load_val;
  logic             load_ok;

  assign in_ready = ~pend_v | grst;
  assign transfer = in_valid & in_ready;
  assign busy     = (state == COUNT);

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pend   <= pend_nxt;
      pend_v <= pend_v_nxt;
      q      <= q_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pend_nxt   = pend;
    pend_v_nxt = pend_v;
    q_nxt      = q;
    load_val   = pend;
    load_ok    = pend_v;

    if (grst) begin
      // A value offered on the same edge takes priority over the buffered one.
      if (transfer) begin
        load_val = in_val;
        load_ok  = 1'b1;
      end
      q_nxt      = 1'b0;
      pend_v_nxt = 1'b0;
      if (load_ok && (load_val != ALL_ONES)) begin
        cnt_nxt   = load_val;
        state_nxt = COUNT;
      end else begin
        state_nxt = IDLE;
      end
    end else begin
      if (transfer) begin
        pend_nxt   = in_val;
        pend_v_nxt = 1'b1;
      end
      case (state)
        COUNT: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - ONE;
          end else begin
            q_nxt     = 1'b1;
            state_nxt = FIRED;
          end
        end
        FIRED: begin
          if (PULSE_MODE) q_nxt = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboard bench: edge-mode and pulse-mode encoders share one stimulus stream;
// expected {q,busy,in_ready} per instance are queued by edge number and popped by monitors.
module tb_spike_encoder;

  localparam int W = 4;

  logic         aclk     = 1'b0;
  logic         rst      = 1'b1;
  logic         grst     = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_val   = '0;
  logic         rdy_e, q_e, busy_e;
  logic         rdy_p, q_p, busy_p;

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int         cyc;
    logic [5:0] v;
    string      name;
  } exp_t;

  exp_t sb[$];

  spike_encoder #(.WIDTH(W), .PULSE_MODE(1'b0)) u_edge (
    .aclk(aclk), .rst(rst), .grst(grst), .in_val(in_val), .in_valid(in_valid),
    .in_ready(rdy_e), .q(q_e), .busy(busy_e)
  );

  spike_encoder #(.WIDTH(W), .PULSE_MODE(1'b1)) u_pulse (
    .aclk(aclk), .rst(rst), .grst(grst), .in_val(in_val), .in_valid(in_valid),
    .in_ready(rdy_p), .q(q_p), .busy(busy_p)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input logic qe, input logic qp,
                           input logic b, input logic r, input string nm);
    exp_t e;
    e.cyc  = c;
    e.v    = {qe, b, r, qp, b, r};
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    logic [5:0] act;
    act = {q_e, busy_e, rdy_e, q_p, busy_p, rdy_p};
    vectors++;
    if (act !== e.v) begin
      miscompares++;
      $display("FAIL %s @edge %0d: got q,busy,rdy edge|pulse = %b, want %b", e.name, cyc, act, e.v);
    end
  endtask

  always @(posedge aclk) begin
    exp_t e;
    #2;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL %s: expectation for edge %0d never checked (now %0d)", e.name, e.cyc, cyc);
      end else begin
        compare(e);
      end
    end
  end

  // Reset must clear outputs without waiting for a clock edge.
  always @(posedge rst) begin
    #1;
    if (sb.size() > 0 && sb[0].cyc == -1) compare(sb.pop_front());
  end

  task automatic step(input logic g, input logic v, input logic [W-1:0] d);
    grst     = g;
    in_valid = v;
    in_val   = d;
    @(negedge aclk);
  endtask

  initial begin
    int k;
    repeat (2) @(negedge aclk);

    // reset state, and no transfer while rst is high
    expect_at(cyc + 1, 0, 0, 0, 1, "reset_state");
    step(0, 1, 4'd4);
    expect_at(cyc + 1, 0, 0, 0, 1, "reset_ready_hi");
    step(0, 1, 4'd4);
    rst = 1'b0;
    step(0, 0, 0);

    // first grst after reset with nothing pending: stays idle
    k = cyc + 1;
    expect_at(k,      0, 0, 0, 1, "empty_grst_k");
    expect_at(k + 10, 0, 0, 0, 1, "empty_grst_k10");
    expect_at(k + 19, 0, 0, 0, 1, "empty_grst_k19");
    step(1, 0, 0);
    repeat (19) step(0, 0, 0);

    // load 3, second offer 8 refused while pending
    expect_at(cyc + 1, 0, 0, 0, 0, "load3_accept");
    step(0, 1, 4'd3);
    expect_at(cyc + 1, 0, 0, 0, 0, "load8_refused");
    step(0, 1, 4'd8);
    k = cyc + 1;
    expect_at(k,     0, 0, 1, 1, "v3_busy_k");
    expect_at(k + 1, 0, 0, 1, 1, "v3_busy_k1");
    expect_at(k + 3, 0, 0, 1, 1, "v3_busy_k3");
    expect_at(k + 4, 1, 1, 0, 1, "v3_fire_k4");
    expect_at(k + 5, 1, 0, 0, 1, "v3_hold_k5");
    expect_at(k + 8, 1, 0, 0, 1, "v3_hold_k8");
    step(1, 0, 0);
    repeat (8) step(0, 0, 0);

    // transfer in FIRED leaves q alone; then bypass 0 on grst edge
    expect_at(cyc + 1, 1, 0, 0, 0, "fired_xfer_q");
    step(0, 1, 4'd5);
    k = cyc + 1;
    expect_at(k,     0, 0, 1, 1, "bypass0_k");
    expect_at(k + 1, 1, 1, 0, 1, "bypass0_fire");
    expect_at(k + 2, 1, 0, 0, 1, "bypass0_hold");
    step(1, 1, 4'd0);
    repeat (2) step(0, 0, 0);

    // all-ones means infinite time
    expect_at(cyc + 1, 1, 0, 0, 0, "load15_accept");
    step(0, 1, 4'd15);
    k = cyc + 1;
    expect_at(k,      0, 0, 0, 1, "inf_k");
    expect_at(k + 5,  0, 0, 0, 1, "inf_k5");
    expect_at(k + 19, 0, 0, 0, 1, "inf_k19");
    step(1, 0, 0);
    repeat (19) step(0, 0, 0);

    // load 9, abort at k+3 with pending 2
    expect_at(cyc + 1, 0, 0, 0, 0, "load9_accept");
    step(0, 1, 4'd9);
    k = cyc + 1;
    expect_at(k,      0, 0, 1, 1, "abort_busy_k");
    expect_at(k + 1,  0, 0, 1, 0, "abort_pend2");
    expect_at(k + 3,  0, 0, 1, 1, "abort_reload");
    expect_at(k + 5,  0, 0, 1, 1, "abort_k5");
    expect_at(k + 6,  1, 1, 0, 1, "abort_fire_k6");
    expect_at(k + 7,  1, 0, 0, 1, "abort_hold_k7");
    expect_at(k + 12, 1, 0, 0, 1, "abort_hold_k12");
    step(1, 0, 0);
    step(0, 1, 4'd2);
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (9) step(0, 0, 0);

    // load 5: pulse exactly one cycle after k+6
    expect_at(cyc + 1, 1, 0, 0, 0, "load5_accept");
    step(0, 1, 4'd5);
    k = cyc + 1;
    expect_at(k,      0, 0, 1, 1, "v5_k");
    expect_at(k + 5,  0, 0, 1, 1, "v5_k5");
    expect_at(k + 6,  1, 1, 0, 1, "v5_fire_k6");
    expect_at(k + 7,  1, 0, 0, 1, "v5_k7");
    expect_at(k + 10, 1, 0, 0, 1, "v5_k10");
    expect_at(k + 16, 1, 0, 0, 1, "v5_k16");
    step(1, 0, 0);
    repeat (16) step(0, 0, 0);

    // load 7, async reset mid-count, no spike afterwards
    expect_at(cyc + 1, 1, 0, 0, 0, "load7_accept");
    step(0, 1, 4'd7);
    k = cyc + 1;
    expect_at(k + 3, 0, 0, 1, 1, "v7_midcount");
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    expect_at(-1, 0, 0, 0, 1, "rst_midcount_async");
    rst = 1'b1;
    repeat (2) step(0, 0, 0);
    rst = 1'b0;
    k = cyc + 1;
    expect_at(k + 5,  0, 0, 0, 1, "post_rst_k5");
    expect_at(k + 10, 0, 0, 0, 1, "post_rst_k10");
    repeat (11) step(0, 0, 0);

    // async reset while q is held high in FIRED
    expect_at(cyc + 1, 0, 0, 0, 0, "load0_accept");
    step(0, 1, 4'd0);
    k = cyc + 1;
    expect_at(k + 1, 1, 1, 0, 1, "v0_fire");
    expect_at(k + 2, 1, 0, 0, 1, "v0_hold");
    step(1, 0, 0);
    repeat (2) step(0, 0, 0);
    expect_at(-1, 0, 0, 0, 1, "rst_fired_async");
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    repeat (2) step(0, 0, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge aclk);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      miscompares += sb.size();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
